// File: rtl/alu_result_collector_if.sv
// Read-side bundle of the ALU result collector.
// Carries the head entry of the result FIFO to the downstream consumer with a
// valid/ready handshake.
//   res_valid  collector -> consumer  FIFO not empty
//   res_data   collector -> consumer  head entry data (2*WIDTH)
//   res_class  collector -> consumer  00 arith, 01 logic, 10 cmp, 11 shift
//   res_carry  collector -> consumer  head entry carry
//   res_ready  consumer -> collector  consumer accepts the head entry
interface alu_result_collector_if #(
  parameter int WIDTH = 16
);
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_data;
  logic [1:0]           res_class;
  logic                 res_carry;

  modport master (
    output res_valid,
    output res_data,
    output res_class,
    output res_carry,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_class,
    input  res_carry,
    output res_ready
  );
endinterface

// File: rtl/alu_result_collector.sv
// Consumer end of the ALU output bundle.
// Samples the ALU result bundle when enable=1, selects the active result class
// by its one-hot flag, widens it to a 2*WIDTH entry and buffers it in a
// first-word-fall-through FIFO read through the rd interface. Keeps per-class
// push counters and sticky overflow / multiple-flag error bits.
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   enable                sample the ALU bundle this cycle
//   Arith_OUT..Carry_OUT  ALU results
//   *_Flag                one-hot result class valid flags
//   clear_err             clears overflow and flag_err
//   rd                    head entry valid/ready read port (master side)
//   fifo_count            occupied FIFO entries
//   overflow, flag_err    sticky error status
//   *_cnt                 successful pushes per class, wrapping
module alu_result_collector #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [2*WIDTH-1:0]        Arith_OUT,
  input  logic [WIDTH-1:0]          Logic_OUT,
  input  logic [1:0]                CMP_OUT,
  input  logic [WIDTH-1:0]          SHIFT_OUT,
  input  logic                      Carry_OUT,
  input  logic                      Arith_Flag,
  input  logic                      Logic_Flag,
  input  logic                      CMP_Flag,
  input  logic                      SHIFT_Flag,
  input  logic                      clear_err,
  alu_result_collector_if.master    rd,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overflow,
  output logic                      flag_err,
  output logic [CNT_W-1:0]          arith_cnt,
  output logic [CNT_W-1:0]          logic_cnt,
  output logic [CNT_W-1:0]          cmp_cnt,
  output logic [CNT_W-1:0]          shift_cnt
);

  localparam int DW    = 2 * WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_CMP   = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;

  // Number of flags raised in a bundle; used to detect illegal multi-flag bundles.
  function automatic logic [2:0] flag_count(input logic [3:0] f);
    flag_count = {2'b00, f[0]} + {2'b00, f[1]} + {2'b00, f[2]} + {2'b00, f[3]};
  endfunction

  // FIFO storage
  logic [DW-1:0]    mem_data_r  [DEPTH];
  logic [1:0]       mem_class_r [DEPTH];
  logic             mem_carry_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Registered outputs
  logic             res_valid_r;
  logic [DW-1:0]    res_data_r;
  logic [1:0]       res_class_r;
  logic             res_carry_r;
  logic             overflow_r;
  logic             flag_err_r;
  logic [CNT_W-1:0] arith_cnt_r;
  logic [CNT_W-1:0] logic_cnt_r;
  logic [CNT_W-1:0] cmp_cnt_r;
  logic [CNT_W-1:0] shift_cnt_r;

  // Next-state helpers
  logic [3:0]       flags_s;
  logic             one_hot_s;
  logic             multi_s;
  logic [DW-1:0]    new_data_s;
  logic [1:0]       new_class_s;
  logic             new_carry_s;
  logic             full_s;
  logic             pop_s;
  logic             push_req_s;
  logic             push_ok_s;
  logic             ovf_set_s;
  logic             ferr_set_s;
  logic [PTR_W-1:0] rd_next_s;
  logic [CW-1:0]    count_next_s;
  logic [DW-1:0]    head_data_s;
  logic [1:0]       head_class_s;
  logic             head_carry_s;

  // Decode the flag bundle and form the widened entry.
  always_comb begin
    flags_s     = {Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag};
    one_hot_s   = (flag_count(flags_s) == 3'd1);
    multi_s     = (flag_count(flags_s) > 3'd1);
    new_data_s  = '0;
    new_class_s = CLS_ARITH;
    new_carry_s = 1'b0;
    case (flags_s)
      4'b1000: begin
        new_data_s  = Arith_OUT;
        new_class_s = CLS_ARITH;
        new_carry_s = Carry_OUT;
      end
      4'b0100: begin
        new_data_s  = {{WIDTH{1'b0}}, Logic_OUT};
        new_class_s = CLS_LOGIC;
      end
      4'b0010: begin
        new_data_s  = {{(DW-2){1'b0}}, CMP_OUT};
        new_class_s = CLS_CMP;
      end
      4'b0001: begin
        new_data_s  = {{WIDTH{1'b0}}, SHIFT_OUT};
        new_class_s = CLS_SHIFT;
      end
      default: begin
        new_data_s  = '0;
        new_class_s = CLS_ARITH;
        new_carry_s = 1'b0;
      end
    endcase
  end

  // Push/pop arbitration, occupancy and the head value seen after this edge.
  always_comb begin
    full_s     = (count_r == FULL_COUNT);
    pop_s      = (count_r != '0) && rd.res_ready;
    push_req_s = enable && one_hot_s;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok_s  = push_req_s && (!full_s || pop_s);
    ovf_set_s  = push_req_s && full_s && !pop_s;
    ferr_set_s = enable && multi_s;

    if (pop_s) begin
      rd_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_next_s = rd_ptr_r;
    end

    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase

    // The slot being written becomes the head when the FIFO is empty after the pop.
    if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
      head_data_s  = new_data_s;
      head_class_s = new_class_s;
      head_carry_s = new_carry_s;
    end else begin
      head_data_s  = mem_data_r[rd_next_s];
      head_class_s = mem_class_r[rd_next_s];
      head_carry_s = mem_carry_r[rd_next_s];
    end
  end

  // FIFO, output registers, counters and sticky status.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i]  <= '0;
        mem_class_r[i] <= 2'b00;
        mem_carry_r[i] <= 1'b0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_class_r <= 2'b00;
      res_carry_r <= 1'b0;
      overflow_r  <= 1'b0;
      flag_err_r  <= 1'b0;
      arith_cnt_r <= '0;
      logic_cnt_r <= '0;
      cmp_cnt_r   <= '0;
      shift_cnt_r <= '0;
    end else begin
      if (push_ok_s) begin
        mem_data_r[wr_ptr_r]  <= new_data_s;
        mem_class_r[wr_ptr_r] <= new_class_s;
        mem_carry_r[wr_ptr_r] <= new_carry_s;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
        case (new_class_s)
          CLS_ARITH: arith_cnt_r <= arith_cnt_r + CNT_W'(1);
          CLS_LOGIC: logic_cnt_r <= logic_cnt_r + CNT_W'(1);
          CLS_CMP:   cmp_cnt_r   <= cmp_cnt_r + CNT_W'(1);
          CLS_SHIFT: shift_cnt_r <= shift_cnt_r + CNT_W'(1);
          default:   arith_cnt_r <= arith_cnt_r;
        endcase
      end
      rd_ptr_r    <= rd_next_s;
      count_r     <= count_next_s;
      res_valid_r <= (count_next_s != '0);
      res_data_r  <= head_data_s;
      res_class_r <= head_class_s;
      res_carry_r <= head_carry_s;

      // A new error in the same cycle as clear_err leaves the bit set.
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clear_err) begin
        overflow_r <= 1'b0;
      end
      if (ferr_set_s) begin
        flag_err_r <= 1'b1;
      end else if (clear_err) begin
        flag_err_r <= 1'b0;
      end
    end
  end

  assign rd.res_valid = res_valid_r;
  assign rd.res_data  = res_data_r;
  assign rd.res_class = res_class_r;
  assign rd.res_carry = res_carry_r;
  assign fifo_count   = count_r;
  assign overflow     = overflow_r;
  assign flag_err     = flag_err_r;
  assign arith_cnt    = arith_cnt_r;
  assign logic_cnt    = logic_cnt_r;
  assign cmp_cnt      = cmp_cnt_r;
  assign shift_cnt    = shift_cnt_r;

endmodule

// File: tb/tb_alu_result_collector.sv
module tb_alu_result_collector;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  cls;
    logic        carry;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [31:0] Arith_OUT;
  logic [15:0] Logic_OUT;
  logic [1:0]  CMP_OUT;
  logic [15:0] SHIFT_OUT;
  logic        Carry_OUT;
  logic        Arith_Flag;
  logic        Logic_Flag;
  logic        CMP_Flag;
  logic        SHIFT_Flag;
  logic        clear_err;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        flag_err;
  logic [7:0]  arith_cnt;
  logic [7:0]  logic_cnt;
  logic [7:0]  cmp_cnt;
  logic [7:0]  shift_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  alu_result_collector_if #(.WIDTH(16)) rd_if ();

  alu_result_collector #(.WIDTH(16), .DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .Arith_OUT  (Arith_OUT),
    .Logic_OUT  (Logic_OUT),
    .CMP_OUT    (CMP_OUT),
    .SHIFT_OUT  (SHIFT_OUT),
    .Carry_OUT  (Carry_OUT),
    .Arith_Flag (Arith_Flag),
    .Logic_Flag (Logic_Flag),
    .CMP_Flag   (CMP_Flag),
    .SHIFT_Flag (SHIFT_Flag),
    .clear_err  (clear_err),
    .rd         (rd_if),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .flag_err   (flag_err),
    .arith_cnt  (arith_cnt),
    .logic_cnt  (logic_cnt),
    .cmp_cnt    (cmp_cnt),
    .shift_cnt  (shift_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted head entry is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rd_if.res_valid === 1'b1 && rd_if.res_ready === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_entry: got data=%h class=%b carry=%b, required no entry",
                 rd_if.res_data, rd_if.res_class, rd_if.res_carry);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rd_if.res_data !== e.data || rd_if.res_class !== e.cls || rd_if.res_carry !== e.carry) begin
          n_fail++;
          $display("FAIL fifo_entry: got data=%h class=%b carry=%b, required data=%h class=%b carry=%b",
                   rd_if.res_data, rd_if.res_class, rd_if.res_carry, e.data, e.cls, e.carry);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable     = 1'b0;
    Arith_Flag = 1'b0;
    Logic_Flag = 1'b0;
    CMP_Flag   = 1'b0;
    SHIFT_Flag = 1'b0;
    clear_err  = 1'b0;
  endtask

  // Drive one bundle for one cycle; f = {Arith, Logic, CMP, SHIFT}.
  task automatic issue(input logic [3:0] f);
    enable = 1'b1;
    {Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag} = f;
    tick(1);
    idle();
  endtask

  task automatic push_shift(input logic [15:0] v, input bit accepted);
    SHIFT_OUT = v;
    if (accepted) sb_q.push_back('{data: {16'h0000, v}, cls: 2'b11, carry: 1'b0});
    issue(4'b0001);
  endtask

  initial begin
    reset_n = 1'b0; rd_if.res_ready = 1'b0;
    Arith_OUT = 32'h0; Logic_OUT = 16'h0; CMP_OUT = 2'b00; SHIFT_OUT = 16'h0; Carry_OUT = 1'b1;
    idle();

    // 1: reset with every flag driven
    enable = 1'b1; {Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag} = 4'b1111;
    tick(2);
    check("rst_valid", {31'd0, rd_if.res_valid}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_data", rd_if.res_data, 32'd0);
    check("rst_cnts", {arith_cnt, logic_cnt, cmp_cnt, shift_cnt}, 32'd0);
    check("rst_err", {30'd0, overflow, flag_err}, 32'd0);
    idle();
    reset_n = 1'b1;
    tick(1);

    // 2: arith push, one-cycle latency
    Arith_OUT = 32'hFFFF_FFF2; Carry_OUT = 1'b1;
    sb_q.push_back('{data: 32'hFFFF_FFF2, cls: 2'b00, carry: 1'b1});
    issue(4'b1000);
    check("arith_valid", {31'd0, rd_if.res_valid}, 32'd1);
    check("arith_data", rd_if.res_data, 32'hFFFF_FFF2);
    check("arith_class_carry", {29'd0, rd_if.res_class, rd_if.res_carry}, 32'b001);
    check("arith_cnt", {24'd0, arith_cnt}, 32'd1);
    rd_if.res_ready = 1'b1;
    tick(2);
    check("arith_drained", {29'd0, fifo_count}, 32'd0);

    // 3: logic then cmp, consumer always ready
    Logic_OUT = 16'hFFFB; CMP_OUT = 2'd3;
    sb_q.push_back('{data: 32'h0000_FFFB, cls: 2'b01, carry: 1'b0});
    issue(4'b0100);
    sb_q.push_back('{data: 32'h0000_0003, cls: 2'b10, carry: 1'b0});
    issue(4'b0010);
    tick(3);
    check("lc_count", {29'd0, fifo_count}, 32'd0);
    check("lc_cnts", {16'd0, logic_cnt, cmp_cnt}, {16'd0, 8'd1, 8'd1});

    // 4: five shift pushes into a 4-deep FIFO
    rd_if.res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_shift(16'(i), i <= 4);
    check("ovf_count", {29'd0, fifo_count}, 32'd4);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_shift_cnt", {24'd0, shift_cnt}, 32'd4);
    rd_if.res_ready = 1'b1;
    tick(6);
    check("ovf_drained", {29'd0, fifo_count}, 32'd0);
    check("ovf_still_set", {31'd0, overflow}, 32'd1);

    // 5: full FIFO, push with simultaneous pop
    rd_if.res_ready = 1'b0;
    clear_err = 1'b1;
    tick(1);
    idle();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    for (int i = 5; i <= 8; i++) push_shift(16'(i), 1'b1);
    check("full_count", {29'd0, fifo_count}, 32'd4);
    rd_if.res_ready = 1'b1;
    push_shift(16'd9, 1'b1);
    rd_if.res_ready = 1'b0;
    check("pp_count", {29'd0, fifo_count}, 32'd4);
    check("pp_no_ovf", {31'd0, overflow}, 32'd0);
    check("pp_shift_cnt", {24'd0, shift_cnt}, 32'd9);
    rd_if.res_ready = 1'b1;
    tick(6);
    check("pp_drained", {29'd0, fifo_count}, 32'd0);

    // 6: multi-flag error, clear, NOP
    issue(4'b1100);
    check("ferr_set", {31'd0, flag_err}, 32'd1);
    check("ferr_no_push", {29'd0, fifo_count}, 32'd0);
    check("ferr_cnts", {arith_cnt, logic_cnt, cmp_cnt, shift_cnt}, {8'd1, 8'd1, 8'd1, 8'd9});
    clear_err = 1'b1;
    tick(1);
    idle();
    check("ferr_clear", {31'd0, flag_err}, 32'd0);
    issue(4'b0000);
    check("nop_ferr", {31'd0, flag_err}, 32'd0);
    check("nop_count", {29'd0, fifo_count}, 32'd0);
    // error and clear in the same cycle: the error wins
    clear_err = 1'b1;
    issue(4'b0011);
    check("ferr_wins", {31'd0, flag_err}, 32'd1);
    clear_err = 1'b1;
    tick(1);
    idle();

    // counter wrap: 255 more logic pushes take logic_cnt from 1 to 0
    for (int i = 0; i < 255; i++) begin
      Logic_OUT = 16'(i * 7);
      sb_q.push_back('{data: {16'h0000, 16'(i * 7)}, cls: 2'b01, carry: 1'b0});
      issue(4'b0100);
    end
    tick(3);
    check("logic_wrap", {24'd0, logic_cnt}, 32'd0);
    check("wrap_drained", {29'd0, fifo_count}, 32'd0);

    // reset mid-stream discards buffered entries
    rd_if.res_ready = 1'b0;
    push_shift(16'hAAAA, 1'b0);
    push_shift(16'h5555, 1'b0);
    check("pre_rst_count", {29'd0, fifo_count}, 32'd2);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    check("mid_rst_valid", {31'd0, rd_if.res_valid}, 32'd0);
    check("mid_rst_cnt", {24'd0, shift_cnt}, 32'd0);
    rd_if.res_ready = 1'b1;
    tick(3);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
